// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel stream deserializer.
package s2p_pkg;

    typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} beat_order_e;

    // Width that can hold beat counts 0..ratio; never collapses to zero bits.
    function automatic int cnt_width(input int ratio);
        return (ratio < 1) ? 1 : $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/s2p_accumulator.sv
// Beat counter and placement: builds the next word and flags the beat that closes it.
module s2p_accumulator
    import s2p_pkg::*;
#(
    parameter int          IN_W  = 1,
    parameter int          OUT_W = 8,
    parameter beat_order_e ORDER = LSB_FIRST,
    localparam int         RATIO = OUT_W / IN_W,
    localparam int         CNT_W = cnt_width(RATIO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_en,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             close,
    output logic [OUT_W-1:0] next_word,
    output logic [CNT_W-1:0] next_count
);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] placed;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_slot;
    int               slot;

    always_comb begin
        slot   = (ORDER == MSB_FIRST) ? (RATIO - 1 - int'(beat_cnt)) : int'(beat_cnt);
        placed = acc;
        for (int s = 0; s < RATIO; s++) begin
            if (s == slot) placed[s*IN_W +: IN_W] = in_data;
        end
    end

    assign last_slot  = (beat_cnt == CNT_W'(RATIO - 1));
    assign close      = beat_en && (in_last || last_slot);
    assign next_word  = placed;
    assign next_count = beat_cnt + CNT_W'(1);

    // Closing beats leave the accumulator empty so the next word starts at slot 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (beat_en) begin
            if (close) begin
                acc      <= '0;
                beat_cnt <= '0;
            end else begin
                acc      <= placed;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_to_parallel_stream.sv
// Packs IN_W-bit beats into OUT_W-bit words with valid/ready on both sides.
module serial_to_parallel_stream
    import s2p_pkg::cnt_width;
    import s2p_pkg::beat_order_e;
#(
    parameter int  IN_W      = 1,
    parameter int  OUT_W     = 8,
    parameter bit  MSB_FIRST = 1'b0,
    localparam int RATIO     = OUT_W / IN_W,
    localparam int CNT_W     = cnt_width(RATIO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    if (IN_W < 1 || (OUT_W % IN_W) != 0) begin : g_param_check
        $error("serial_to_parallel_stream: OUT_W must be a positive multiple of IN_W");
    end

    logic             beat_en;
    logic             close;
    logic [OUT_W-1:0] next_word;
    logic [CNT_W-1:0] next_count;

    // Any beat waits while a word is held, so one holding register suffices.
    assign in_ready = !out_valid || out_ready;
    assign beat_en  = in_valid && in_ready;

    s2p_accumulator #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ORDER (beat_order_e'(MSB_FIRST))
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_en    (beat_en),
        .in_data    (in_data),
        .in_last    (in_last),
        .close      (close),
        .next_word  (next_word),
        .next_count (next_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_data  <= next_word;
            out_count <= next_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Directed and randomized checks of the deserializer in three configurations.
module tb_serial_to_parallel_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // a: IN_W=1 LSB-first, b: IN_W=1 MSB-first (same stimulus), c: IN_W=4 OUT_W=16
    logic       ab_in_valid, ab_in_last, ab_out_ready;
    logic [0:0] ab_in_data;
    logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [7:0] a_out_data, b_out_data;
    logic [3:0] a_out_count, b_out_count;

    logic        c_in_valid, c_in_last, c_out_ready, c_in_ready, c_out_valid;
    logic [3:0]  c_in_data;
    logic [15:0] c_out_data;
    logic [2:0]  c_out_count;

    serial_to_parallel_stream #(.IN_W(1), .OUT_W(8), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(ab_in_valid), .in_ready(a_in_ready),
        .in_data(ab_in_data), .in_last(ab_in_last), .out_valid(a_out_valid),
        .out_ready(ab_out_ready), .out_data(a_out_data), .out_count(a_out_count));

    serial_to_parallel_stream #(.IN_W(1), .OUT_W(8), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(ab_in_valid), .in_ready(b_in_ready),
        .in_data(ab_in_data), .in_last(ab_in_last), .out_valid(b_out_valid),
        .out_ready(ab_out_ready), .out_data(b_out_data), .out_count(b_out_count));

    serial_to_parallel_stream #(.IN_W(4), .OUT_W(16), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_count(c_out_count));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives n beats of a packed word into dut_c (ready is held high), then checks the result.
    task automatic c_word(input string tag, input logic [15:0] beats, input int n,
                          input bit use_last, input logic [15:0] exp_w, input logic [2:0] exp_c);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c_in_valid = 1'b1;
            c_in_data  = 4'(beats >> (4 * k));
            c_in_last  = use_last && (k == n - 1);
        end
        @(negedge clk);
        c_in_valid = 1'b0;
        c_in_last  = 1'b0;
        check({tag, "_valid"}, c_out_valid, 1'b1);
        check({tag, "_data"},  c_out_data,  exp_w);
        check({tag, "_count"}, c_out_count, exp_c);
    endtask

    logic [7:0]  w;
    logic        seen;
    logic [15:0] exp_w[$];
    logic [2:0]  exp_c[$];
    logic [15:0] cur_w, hold_w, ew;
    logic [2:0]  hold_c, ec;
    logic        hold;
    int          cur_n, beats, cyc;

    initial begin
        rst_n = 1'b0;
        ab_in_valid = 1'b0; ab_in_data = '0; ab_in_last = 1'b0; ab_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  a_in_ready,  1'b1);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_out_data",  a_out_data,  8'h00);
        check("rst_out_count", a_out_count, 4'd0);
        rst_n = 1'b1;

        // Bits 1,0,1,1,0,0,1,0 in arrival order: LSB-first 4D, MSB-first B2
        w = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) check("t1_no_early_valid", a_out_valid, 1'b0);
            ab_in_valid = 1'b1;
            ab_in_data  = 1'(w >> i);
        end
        @(negedge clk);
        ab_in_valid = 1'b0;
        check("t1_valid", a_out_valid, 1'b1);
        check("t1_data",  a_out_data,  8'h4D);
        check("t1_count", a_out_count, 4'd8);
        check("t2_data",  b_out_data,  8'hB2);
        check("t2_count", b_out_count, 4'd8);
        @(negedge clk);
        check("t1_valid_drop", a_out_valid, 1'b0);

        // Partial words, 1-beat word and in_last on the final slot
        c_word("t3_partial", 16'h00A3, 2, 1'b1, 16'h00A3, 3'd2);
        c_word("t3_restart", 16'h8765, 4, 1'b0, 16'h8765, 3'd4);
        c_word("t3_single",  16'h000F, 1, 1'b1, 16'h000F, 3'd1);
        c_word("t3_last_full", 16'h4321, 4, 1'b1, 16'h4321, 3'd4);
        @(negedge clk);

        // Backpressure: held word stays stable, then same-cycle transfer and accept
        ab_out_ready = 1'b0;
        w = 8'hC5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ab_in_valid = 1'b1;
            ab_in_data  = 1'(w >> i);
        end
        w = 8'h3A;
        @(negedge clk);
        ab_in_data = 1'(w);
        check("t4_held_valid", a_out_valid, 1'b1);
        check("t4_held_data",  a_out_data,  8'hC5);
        check("t4_stall",      a_in_ready,  1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stable_valid", a_out_valid, 1'b1);
            check("t4_stable_data",  a_out_data,  8'hC5);
            check("t4_stable_count", a_out_count, 4'd8);
            check("t4_stable_stall", a_in_ready,  1'b0);
        end
        ab_out_ready = 1'b1;
        #1;
        check("t4_ready_on_take", a_in_ready, 1'b1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) check("t4_taken", a_out_valid, 1'b0);
            ab_in_data = 1'(w >> i);
        end
        @(negedge clk);
        ab_in_valid = 1'b0;
        check("t4_next_valid", a_out_valid, 1'b1);
        check("t4_next_data",  a_out_data,  8'h3A);
        check("t4_next_count", a_out_count, 4'd8);
        @(negedge clk);

        // Reset mid-word discards the partial beats
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ab_in_valid = 1'b1;
            ab_in_data  = 1'b1;
        end
        @(negedge clk);
        ab_in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_ready", a_in_ready, 1'b1);
        rst_n = 1'b1;
        check("t5_rst_valid", a_out_valid, 1'b0);
        w = 8'h96;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | a_out_valid;
            ab_in_valid = 1'b1;
            ab_in_data  = 1'(w >> i);
        end
        @(negedge clk);
        ab_in_valid = 1'b0;
        check("t5_no_stale_word", seen, 1'b0);
        check("t5_valid", a_out_valid, 1'b1);
        check("t5_data",  a_out_data,  8'h96);
        check("t5_count", a_out_count, 4'd8);
        @(negedge clk);

        // Random traffic on dut_c against a word-level scoreboard
        cur_w = '0; cur_n = 0; beats = 0; cyc = 0; hold = 1'b0; hold_w = '0; hold_c = '0;
        while (beats < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            check("rnd_valid_vs_model", c_out_valid, exp_w.size() > 0);
            if (hold) begin
                check("rnd_hold_data",  c_out_data,  hold_w);
                check("rnd_hold_count", c_out_count, hold_c);
            end
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_in_data   = 4'($urandom);
            c_in_last   = ($urandom_range(0, 4) == 0);
            c_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (c_out_valid && c_out_ready) begin
                if (exp_w.size() == 0) begin
                    check("rnd_spurious_word", exp_w.size(), 1);
                end else begin
                    ew = exp_w.pop_front();
                    ec = exp_c.pop_front();
                    check("rnd_data",  c_out_data,  ew);
                    check("rnd_count", c_out_count, ec);
                end
            end
            if (c_in_valid && c_in_ready) begin
                cur_w = cur_w | (16'(c_in_data) << (4 * cur_n));
                cur_n++;
                beats++;
                if (c_in_last || cur_n == 4) begin
                    exp_w.push_back(cur_w);
                    exp_c.push_back(3'(cur_n));
                    cur_w = '0;
                    cur_n = 0;
                end
            end
            hold   = c_out_valid && !c_out_ready;
            hold_w = c_out_data;
            hold_c = c_out_count;
        end
        check("rnd_beat_budget", beats >= 10000, 1'b1);
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        @(negedge clk);
        if (c_out_valid && exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            ec = exp_c.pop_front();
            check("rnd_drain_data",  c_out_data,  ew);
            check("rnd_drain_count", c_out_count, ec);
        end
        @(negedge clk);
        check("rnd_drain_valid", c_out_valid, 1'b0);
        check("rnd_queue_empty", exp_w.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
